// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared access-size encodings, LSU state type and alignment rule
package mips_pkg;

   localparam logic [1:0] SIZE_BYTE = 2'b00;
   localparam logic [1:0] SIZE_HALF = 2'b01;
   localparam logic [1:0] SIZE_WORD = 2'b10;
   localparam logic [1:0] SIZE_RSVD = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2,
      ST_DONE = 2'd3
   } lsu_state_t;

   // The reserved size is rejected the same way as a misaligned address.
   function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lo);
      return (size == SIZE_HALF && lo[0]) ||
             (size == SIZE_WORD && lo != 2'b00) ||
             (size == SIZE_RSVD);
   endfunction

endpackage

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - byte enables, store lane replication and load extraction/extension
module lsu_align
   import mips_pkg::*;
(
   input  logic [1:0]  st_size,
   input  logic [1:0]  st_lane,
   input  logic [31:0] wdata,
   output logic [3:0]  be,
   output logic [31:0] wdata_rep,
   input  logic [1:0]  ld_size,
   input  logic [1:0]  ld_lane,
   input  logic        ld_unsigned,
   input  logic [31:0] raw,
   output logic [31:0] ext
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      be        = 4'b1111;
      wdata_rep = wdata;
      case (st_size)
         SIZE_BYTE: begin
            be        = 4'b0001 << st_lane;
            wdata_rep = {4{wdata[7:0]}};
         end
         SIZE_HALF: begin
            be        = st_lane[1] ? 4'b1100 : 4'b0011;
            wdata_rep = {2{wdata[15:0]}};
         end
         default: begin
            be        = 4'b1111;
            wdata_rep = wdata;
         end
      endcase
   end

   always_comb begin
      byte_sel = raw[7:0];
      case (ld_lane)
         2'd0:    byte_sel = raw[7:0];
         2'd1:    byte_sel = raw[15:8];
         2'd2:    byte_sel = raw[23:16];
         default: byte_sel = raw[31:24];
      endcase
      half_sel = ld_lane[1] ? raw[31:16] : raw[15:0];
      ext = raw;
      case (ld_size)
         SIZE_BYTE: ext = ld_unsigned ? {24'd0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
         SIZE_HALF: ext = ld_unsigned ? {16'd0, half_sel} : {{16{half_sel[15]}}, half_sel};
         default:   ext = raw;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - single-access data-memory stage with stall, timeout and bus handshake
module load_store_unit
   import mips_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 256
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        mem_read,
   input  logic        mem_write,
   input  logic [1:0]  mem_size,
   input  logic        mem_unsigned,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic        stall,
   output logic [31:0] rdata,
   output logic        addr_err,
   output logic        bus_err,
   output logic        req_valid,
   input  logic        req_ready,
   output logic        req_we,
   output logic [31:0] req_addr,
   output logic [3:0]  req_be,
   output logic [31:0] req_wdata,
   input  logic        rsp_valid,
   input  logic [31:0] rsp_rdata
);

   localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYCLES - 1);

   lsu_state_t  state;
   logic        op;
   logic        mis;
   logic        timeout_hit;
   logic [31:0] cnt;
   logic [1:0]  ld_size;
   logic [1:0]  ld_lane;
   logic        ld_uns;
   logic [3:0]  st_be;
   logic [31:0] st_wdata;
   logic [31:0] ld_data;

   lsu_align u_align (
      .st_size     (mem_size),
      .st_lane     (addr[1:0]),
      .wdata       (wdata),
      .be          (st_be),
      .wdata_rep   (st_wdata),
      .ld_size     (ld_size),
      .ld_lane     (ld_lane),
      .ld_unsigned (ld_uns),
      .raw         (rsp_rdata),
      .ext         (ld_data)
   );

   assign op          = mem_read | mem_write;
   assign mis         = misaligned(mem_size, addr[1:0]);
   assign stall       = (state == ST_IDLE && op && !mis) || state == ST_REQ || state == ST_WAIT;
   assign addr_err    = state == ST_IDLE && op && mis;
   assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt == TO_LAST);

   // A completing handshake or response in the same cycle as the timeout wins.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= ST_IDLE;
         req_valid <= 1'b0;
         req_we    <= 1'b0;
         req_addr  <= 32'd0;
         req_be    <= 4'd0;
         req_wdata <= 32'd0;
         rdata     <= 32'd0;
         bus_err   <= 1'b0;
         cnt       <= 32'd0;
         ld_size   <= 2'd0;
         ld_lane   <= 2'd0;
         ld_uns    <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (op && !mis) begin
                  state     <= ST_REQ;
                  req_valid <= 1'b1;
                  req_we    <= mem_write;
                  req_addr  <= {addr[31:2], 2'b00};
                  req_be    <= st_be;
                  req_wdata <= st_wdata;
                  ld_size   <= mem_size;
                  ld_lane   <= addr[1:0];
                  ld_uns    <= mem_unsigned;
                  cnt       <= 32'd0;
               end
            end
            ST_REQ: begin
               cnt <= cnt + 32'd1;
               if (req_ready) begin
                  req_valid <= 1'b0;
                  state     <= req_we ? ST_DONE : ST_WAIT;
               end else if (timeout_hit) begin
                  req_valid <= 1'b0;
                  bus_err   <= 1'b1;
                  rdata     <= 32'd0;
                  state     <= ST_DONE;
               end
            end
            ST_WAIT: begin
               cnt <= cnt + 32'd1;
               if (rsp_valid) begin
                  rdata <= ld_data;
                  state <= ST_DONE;
               end else if (timeout_hit) begin
                  bus_err <= 1'b1;
                  rdata   <= 32'd0;
                  state   <= ST_DONE;
               end
            end
            ST_DONE: begin
               bus_err <= 1'b0;
               state   <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - directed scoreboard bench for load_store_unit
module tb_load_store_unit;
   import mips_pkg::*;

   localparam int TO = 12;

   logic        clk;
   logic        reset;
   logic        mem_read;
   logic        mem_write;
   logic [1:0]  mem_size;
   logic        mem_unsigned;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        stall;
   logic [31:0] rdata;
   logic        addr_err;
   logic        bus_err;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [31:0] req_addr;
   logic [3:0]  req_be;
   logic [31:0] req_wdata;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [3:0]  be;
      logic [31:0] wd;
      logic        chk_wd;
   } req_t;

   req_t        req_q[$];
   logic [32:0] rd_q[$];
   int          checks = 0;
   int          errors = 0;

   load_store_unit #(.TIMEOUT_CYCLES(TO)) dut (
      .clk          (clk),
      .reset        (reset),
      .mem_read     (mem_read),
      .mem_write    (mem_write),
      .mem_size     (mem_size),
      .mem_unsigned (mem_unsigned),
      .addr         (addr),
      .wdata        (wdata),
      .stall        (stall),
      .rdata        (rdata),
      .addr_err     (addr_err),
      .bus_err      (bus_err),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_we       (req_we),
      .req_addr     (req_addr),
      .req_be       (req_be),
      .req_wdata    (req_wdata),
      .rsp_valid    (rsp_valid),
      .rsp_rdata    (rsp_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle again.
   task automatic access(input string tag, input logic rd, input logic wr, input logic [1:0] sz,
                         input logic uns, input logic [31:0] a, input logic [31:0] wd,
                         input int rdy_lat, input int rsp_lat, input logic [31:0] raw,
                         input logic [3:0] exp_be, input logic [31:0] exp_wd,
                         input logic [31:0] exp_rd, input logic exp_berr, input int exp_stalls);
      int          stalls;
      int          req_cyc;
      int          wait_cyc;
      logic        hs;
      logic        done;
      req_t        er;
      logic [32:0] erd;
      er.we = wr; er.addr = {a[31:2], 2'b00}; er.be = exp_be; er.wd = exp_wd; er.chk_wd = wr;
      req_q.push_back(er);
      rd_q.push_back({exp_berr, exp_rd});
      mem_read = rd; mem_write = wr; mem_size = sz; mem_unsigned = uns; addr = a; wdata = wd;
      stalls = 0; req_cyc = 0; wait_cyc = 0; hs = 1'b0; done = 1'b0;
      #1 check({tag, ".addr_err"}, 64'(addr_err), 64'd0);
      for (int c = 0; c < 200; c++) begin
         if (c != 0) #1;
         if (!stall) begin
            done = 1'b1;
            break;
         end
         stalls++;
         req_ready = 1'b0;
         rsp_valid = 1'b0;
         if (req_valid) begin
            if (req_q.size() == 0) begin
               check({tag, ".unexpected_req"}, 64'd1, 64'd0);
            end else begin
               er = req_q[0];
               check({tag, ".req_we"}, 64'(req_we), 64'(er.we));
               check({tag, ".req_addr"}, 64'(req_addr), 64'(er.addr));
               check({tag, ".req_be"}, 64'(req_be), 64'(er.be));
               if (er.chk_wd) check({tag, ".req_wdata"}, 64'(req_wdata), 64'(er.wd));
               if (req_cyc >= rdy_lat) begin
                  req_ready = 1'b1;
                  hs = 1'b1;
                  void'(req_q.pop_front());
               end
            end
            req_cyc++;
         end else if (hs) begin
            wait_cyc++;
            if (wait_cyc >= rsp_lat) begin
               rsp_valid = 1'b1;
               rsp_rdata = raw;
            end
         end
         if (stalls > 1) begin
            addr = ~a; wdata = ~wd; mem_size = ~sz; mem_unsigned = ~uns;
         end
         @(negedge clk);
      end
      check({tag, ".done_reached"}, 64'(done), 64'd1);
      check({tag, ".stall_cycles"}, 64'(stalls), 64'(exp_stalls));
      check({tag, ".req_valid_done"}, 64'(req_valid), 64'd0);
      if (!hs && req_q.size() > 0) void'(req_q.pop_front());
      if (rd_q.size() == 0) begin
         check({tag, ".rd_q_empty"}, 64'd1, 64'd0);
      end else begin
         erd = rd_q.pop_front();
         check({tag, ".bus_err"}, 64'(bus_err), 64'(erd[32]));
         if (rd) check({tag, ".rdata"}, 64'(rdata), 64'(erd[31:0]));
      end
      mem_read = 1'b0; mem_write = 1'b0; req_ready = 1'b0; rsp_valid = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      reset = 1'b1;
      mem_read = 1'b0; mem_write = 1'b0; mem_size = SIZE_WORD; mem_unsigned = 1'b0;
      addr = 32'd0; wdata = 32'd0; req_ready = 1'b0; rsp_valid = 1'b0; rsp_rdata = 32'd0;
      @(negedge clk);
      @(negedge clk);
      check("rst.req_valid", 64'(req_valid), 64'd0);
      check("rst.req_we", 64'(req_we), 64'd0);
      check("rst.req_addr", 64'(req_addr), 64'd0);
      check("rst.req_be", 64'(req_be), 64'd0);
      check("rst.req_wdata", 64'(req_wdata), 64'd0);
      check("rst.rdata", 64'(rdata), 64'd0);
      check("rst.bus_err", 64'(bus_err), 64'd0);
      check("rst.stall", 64'(stall), 64'd0);
      check("rst.addr_err", 64'(addr_err), 64'd0);
      reset = 1'b0;
      @(negedge clk);

      access("sw",      0, 1, SIZE_WORD, 0, 32'h100, 32'hDEADBEEF, 0, 0, 32'h0,
             4'b1111, 32'hDEADBEEF, 32'h0, 0, 2);
      access("sb",      0, 1, SIZE_BYTE, 0, 32'h103, 32'h000000A5, 0, 0, 32'h0,
             4'b1000, 32'hA5A5A5A5, 32'h0, 0, 2);
      access("sh",      0, 1, SIZE_HALF, 0, 32'h102, 32'h1234BEEF, 0, 0, 32'h0,
             4'b1100, 32'hBEEFBEEF, 32'h0, 0, 2);
      access("sb_slow", 0, 1, SIZE_BYTE, 0, 32'h100, 32'h00000033, 2, 0, 32'h0,
             4'b0001, 32'h33333333, 32'h0, 0, 4);
      access("rw_both", 1, 1, SIZE_WORD, 0, 32'h108, 32'hCAFEF00D, 0, 0, 32'h0,
             4'b1111, 32'hCAFEF00D, 32'h0, 0, 2);
      access("lb",      1, 0, SIZE_BYTE, 0, 32'h102, 32'h0, 0, 1, 32'h0080FF00,
             4'b0100, 32'h0, 32'hFFFFFF80, 0, 3);
      access("lbu",     1, 0, SIZE_BYTE, 1, 32'h102, 32'h0, 0, 1, 32'h0080FF00,
             4'b0100, 32'h0, 32'h00000080, 0, 3);
      access("lh",      1, 0, SIZE_HALF, 0, 32'h102, 32'h0, 0, 1, 32'h80011234,
             4'b1100, 32'h0, 32'hFFFF8001, 0, 3);
      access("lhu",     1, 0, SIZE_HALF, 1, 32'h100, 32'h0, 0, 1, 32'h8001F00D,
             4'b0011, 32'h0, 32'h0000F00D, 0, 3);
      access("lb_pos",  1, 0, SIZE_BYTE, 0, 32'h101, 32'h0, 0, 1, 32'h00007F00,
             4'b0010, 32'h0, 32'h0000007F, 0, 3);
      access("lw_slow", 1, 0, SIZE_WORD, 0, 32'h104, 32'h0, 5, 3, 32'h12345678,
             4'b1111, 32'h0, 32'h12345678, 0, 10);
      access("timeout", 1, 0, SIZE_WORD, 0, 32'h200, 32'h0, 1000, 1000, 32'h0,
             4'b1111, 32'h0, 32'h0, 1, TO + 1);
      access("after_to", 0, 1, SIZE_WORD, 0, 32'h204, 32'h01020304, 0, 0, 32'h0,
             4'b1111, 32'h01020304, 32'h0, 0, 2);

      mem_read = 1'b1; mem_size = SIZE_WORD; addr = 32'h101;
      #1 check("mis_w.addr_err", 64'(addr_err), 64'd1);
      check("mis_w.stall", 64'(stall), 64'd0);
      @(negedge clk);
      @(negedge clk);
      check("mis_w.req_valid", 64'(req_valid), 64'd0);
      check("mis_w.addr_err_held", 64'(addr_err), 64'd1);
      mem_size = SIZE_RSVD; addr = 32'h100;
      #1 check("rsvd.addr_err", 64'(addr_err), 64'd1);
      check("rsvd.stall", 64'(stall), 64'd0);
      mem_size = SIZE_HALF; addr = 32'h103;
      #1 check("mis_h.addr_err", 64'(addr_err), 64'd1);
      @(negedge clk);
      check("mis_h.req_valid", 64'(req_valid), 64'd0);
      mem_read = 1'b0;
      #1 check("noop.addr_err", 64'(addr_err), 64'd0);
      @(negedge clk);

      mem_read = 1'b1; mem_size = SIZE_WORD; addr = 32'h300; wdata = 32'h77777777; req_ready = 1'b1;
      @(negedge clk);
      check("rst_mid.req_valid", 64'(req_valid), 64'd1);
      @(negedge clk);
      req_ready = 1'b0;
      #1 check("rst_mid.in_wait", 64'({stall, req_valid}), 64'b10);
      reset = 1'b1;
      mem_read = 1'b0;
      #1 check("rst_mid.req_valid0", 64'(req_valid), 64'd0);
      check("rst_mid.req_addr", 64'(req_addr), 64'd0);
      check("rst_mid.req_be", 64'(req_be), 64'd0);
      check("rst_mid.req_wdata", 64'(req_wdata), 64'd0);
      check("rst_mid.stall", 64'(stall), 64'd0);
      @(negedge clk);
      reset = 1'b0;
      rsp_valid = 1'b1; rsp_rdata = 32'h55AA55AA;
      @(negedge clk);
      rsp_valid = 1'b0;
      #1 check("late_rsp.rdata", 64'(rdata), 64'd0);
      check("late_rsp.stall", 64'(stall), 64'd0);
      check("late_rsp.bus_err", 64'(bus_err), 64'd0);
      @(negedge clk);

      access("recover", 1, 0, SIZE_WORD, 0, 32'h400, 32'h0, 0, 1, 32'h0BADF00D,
             4'b1111, 32'h0, 32'h0BADF00D, 0, 3);
      check("scoreboard.req_q", 64'(req_q.size()), 64'd0);
      check("scoreboard.rd_q", 64'(rd_q.size()), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Data-memory access stage directly downstream of the ALU: takes the ALU result as the effective address plus the store operand, and runs one load or store per instruction over a valid/ready memory bus. Handles byte/half/word lane steering, byte enables, sign/zero extension and alignment checks. Stalls the single-cycle core until the access completes, then returns load data to the write-back mux.

## Interface
- TIMEOUT_CYCLES, default 256: cycles allowed in REQ+WAIT before bus_err; 0 disables the timeout.
- clk  in  1  core clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high.
- mem_read  in  1  current instruction is a load.
- mem_write  in  1  current instruction is a store; wins if both set.
- mem_size  in  2  00 byte, 01 half, 10 word, 11 reserved.
- mem_unsigned  in  1  zero-extend loads (LBU/LHU) when 1, sign-extend when 0.
- addr  in  32  effective address (ALU result).
- wdata  in  32  store operand (rt).
- stall  out  1  hold PC and pipeline-free core state this cycle.
- rdata  out  32  extended load data, valid while state DONE.
- addr_err  out  1  misaligned/reserved access, combinational in IDLE.
- bus_err  out  1  timeout occurred, valid while state DONE.
- req_valid  out  1  memory request valid.
- req_ready  in  1  memory accepts request.
- req_we  out  1  1 = write.
- req_addr  out  32  word address, bits [1:0] = 00.
- req_be  out  4  byte enables, bit i = byte lane i.
- req_wdata  out  32  lane-replicated store data.
- rsp_valid  in  1  read data valid.
- rsp_rdata  in  32  raw read word.

## Operation
- States: IDLE, REQ, WAIT, DONE.
- IDLE: op = mem_read|mem_write. Misaligned = (half & addr[0]) | (word & addr[1:0]!=0) | size==11. op & misaligned -> addr_err=1, stall=0, no request, stay IDLE. op & aligned -> stall=1, register req fields, go REQ. No op -> stall=0.
- REQ: req_valid=1, fields held stable until req_ready. Handshake: write -> DONE; read -> WAIT.
- WAIT: rsp_valid captures lane-extracted, extended data into rdata -> DONE. rsp_valid outside WAIT ignored.
- DONE: stall=0 (core advances on this edge), rdata/bus_err valid; next state IDLE unconditionally.
- stall=1 in IDLE-with-aligned-op, REQ, WAIT; 0 in DONE and otherwise.
- Little-endian lanes. Byte: req_be = 1<<addr[1:0], req_wdata = {4{wdata[7:0]}}. Half: req_be = addr[1] ? 1100 : 0011, req_wdata = {2{wdata[15:0]}}. Word: 1111, wdata.
- Load extract: byte lane addr[1:0], half lane addr[1]; extend to 32 per mem_unsigned; word passes through.
- Timeout: counter cleared on IDLE->REQ, increments in REQ/WAIT; reaching TIMEOUT_CYCLES -> req_valid drops, go DONE, bus_err=1, rdata=0. bus_err cleared on leaving DONE.

## Timing
- Reset values: state IDLE, req_valid 0, req_we 0, req_addr 0, req_be 0, req_wdata 0, rdata 0, bus_err 0, counter 0. stall/addr_err are combinational from inputs in IDLE.
- Reset mid-operation: immediate return to IDLE; outstanding request abandoned, late rsp_valid ignored.
- Store, req_ready=1: 3 cycles (IDLE, REQ, DONE). Load, ready=1, rsp next cycle: 4 cycles.
- req_ready sampled only in REQ; rsp_valid only in WAIT; same-cycle ready+rsp treated as ready only.
- Inputs (addr, wdata, size, flags) only sampled in IDLE; changes during REQ/WAIT have no effect.

## Structure
- Shared package mips_pkg: size encodings SIZE_BYTE/SIZE_HALF/SIZE_WORD, lsu_state_t enum.
- One sub-module lsu_align: combinational byte-enable, store replication and load extraction/extension; FSM and timeout counter stay in load_store_unit.

## Test plan
- SW addr=0x100, wdata=0xDEADBEEF, ready=1 -> one req: we=1, addr 0x100, be 1111; stall high 2 cycles, low in DONE.
- SB addr=0x103, wdata=0x000000A5 -> req_addr 0x100, be 1000, req_wdata 0xA5A5A5A5.
- LB addr=0x102, rsp 0x0080FF00: signed -> rdata 0xFFFFFF80; LBU -> 0x00000080. LH addr=0x102 rsp 0x8001xxxx -> 0xFFFF8001.
- LW addr=0x101 -> addr_err=1, stall=0, req_valid never asserted; size=11 same result.
- req_ready low 5 cycles then high, rsp 3 cycles later -> req fields stable throughout, stall until DONE, correct rdata.
- TIMEOUT_CYCLES=8, never ready -> bus_err=1 in DONE after 8 cycles, rdata=0; reset asserted in WAIT -> IDLE next, outputs at reset values.
